plab5_mcore_debug_arbiter: RTL
==============================

Name: plab5_mcore_debug_arbiter

Overview:
- Shares the single debug interface between two debug requesters, e.g. a secure debugger port and a non-secure debugger port.
- Arbitrates round-robin and forwards one debug transaction at a time: source address, destination address and domain.
- Waits for the debug interface to report its result, then returns the result data to the requester that won.
- Sits between the external debug ports and the debug interface in the multicore top level.

Parameters:
- p_addr_nbits, 32, width of the address fields
- p_data_nbits, 32, width of the result data
- p_timeout, 256, watchdog limit in cycles; used only with the optional feature

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- req0_val  input  1  requester 0 has a debug request
- req0_rdy  output  1  arbiter accepts the requester 0 request
- req0_src_addr  input  p_addr_nbits  requester 0 source address
- req0_dest_addr  input  p_addr_nbits  requester 0 destination address
- req0_domain  input  1  requester 0 security domain
- req1_val, req1_rdy, req1_src_addr, req1_dest_addr, req1_domain  same as the requester 0 ports, for requester 1
- resp0_val  output  1  result is valid for requester 0
- resp0_rdy  input  1  requester 0 takes the result
- resp0_data  output  p_data_nbits  result data for requester 0
- resp0_err  output  1  transaction aborted (optional feature only)
- resp1_val, resp1_rdy, resp1_data, resp1_err  same as the resp0 ports, for requester 1
- db_val  output  1  new debug instruction to the debug interface
- db_src_addr  output  p_addr_nbits  forwarded source address
- db_dest_addr  output  p_addr_nbits  forwarded destination address
- db_domain  output  1  forwarded security domain
- db_result_rdy  input  1  debug interface result is ready (one-cycle pulse)
- db_result  input  p_data_nbits  debug interface result data

Behaviour:
- Clock and reset: clk is the single clock. reset is asynchronous and active-high.
- Reset values: state IDLE, priority pointer at requester 0. Every output is 0: all rdy, val, err, data and address outputs. Capture registers are cleared to 0.
- State IDLE:
  - req0_rdy = grant0 and req1_rdy = grant1, computed combinationally. They are asserted only in IDLE.
  - If only one requester has val=1, that requester is granted.
  - If both have val=1, the requester named by the priority pointer is granted.
  - On a fire (val & rdy): capture src_addr, dest_addr and domain; record the owner; go to ISSUE.
- State ISSUE:
  - db_val=1 for exactly one cycle, then go to BUSY.
- Address and domain outputs:
  - db_src_addr, db_dest_addr and db_domain come from the capture registers.
  - They are held stable from ISSUE until the arbiter returns to IDLE.
  - They are 0 while in IDLE.
- State BUSY:
  - On db_result_rdy=1, latch db_result into the result register and go to RESP.
  - A db_result_rdy pulse in any state other than BUSY is ignored.
- State RESP:
  - respN_val=1 for the owner only. respN_data = result register, held until respN_rdy=1.
  - On handshake: priority pointer = the other requester; go to IDLE.
  - No new grant is issued in the same cycle as the handshake.
- Response data outside RESP: respN_data is driven to 0. The non-owner never sees val.
- Latency: request fire to db_val is 1 cycle. db_result_rdy to resp_val is 1 cycle. Minimum turnaround with resp_rdy held high is 4 cycles plus the debug interface latency.
- Requests and val: a requester holding val while another transaction is active stalls with rdy=0; its request is neither dropped nor captured. The arbiter never changes a request.
- Reset mid-operation: returns to IDLE immediately. db_val and resp_val deassert asynchronously, and any outstanding transaction is abandoned.

Optional Feature:
- Macro: PLAB5_MCORE_DEBUG_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When the count reaches p_timeout-1 without db_result_rdy, go to RESP with respN_err=1 and respN_data=0.
  - A db_result_rdy pulse in the same cycle as the timeout wins: err=0, data latched.
- Not defined: no counter exists, BUSY waits indefinitely, and resp0_err and resp1_err are tied to 0.

Test Plan:
- Reset then req0_val=1, src=0x100, dest=0x200, domain=0 -> req0_rdy=1. Next cycle db_val=1 with src=0x100, dest=0x200, domain=0. Then db_result_rdy with db_result=0xDEADBEEF -> resp0_val=1 and resp0_data=0xDEADBEEF one cycle later.
- req0_val and req1_val both asserted continuously, resp rdy held high -> grants alternate 0,1,0,1. db_domain follows the domain of the granted requester.
- resp1_rdy held low for 5 cycles in RESP -> resp1_val and resp1_data stay stable. req0_rdy stays 0 until the handshake.
- Stray db_result_rdy pulse in IDLE -> no state change and no resp_val.
- Reset asserted during BUSY -> all outputs 0 immediately. A following request completes normally with the priority pointer back at requester 0.
- With PLAB5_MCORE_DEBUG_ARBITER_TIMEOUT_EN and p_timeout=8, no db_result_rdy -> resp0_val=1 and resp0_err=1 with resp0_data=0 after 8 BUSY cycles.

Source files
------------

// File: rtl/plab5_mcore_debug_arbiter.sv
// Round-robin arbiter sharing one debug interface between two debug requesters.
// Optional BUSY watchdog enabled by defining PLAB5_MCORE_DEBUG_ARBITER_TIMEOUT_EN.
module plab5_mcore_debug_arbiter #(
    parameter int p_addr_nbits = 32,
    parameter int p_data_nbits = 32,
    parameter int p_timeout    = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [p_addr_nbits-1:0] req0_src_addr,
    input  logic [p_addr_nbits-1:0] req0_dest_addr,
    input  logic                    req0_domain,
    input  logic                    req1_val,
    output logic                    req1_rdy,
    input  logic [p_addr_nbits-1:0] req1_src_addr,
    input  logic [p_addr_nbits-1:0] req1_dest_addr,
    input  logic                    req1_domain,
    output logic                    resp0_val,
    input  logic                    resp0_rdy,
    output logic [p_data_nbits-1:0] resp0_data,
    output logic                    resp0_err,
    output logic                    resp1_val,
    input  logic                    resp1_rdy,
    output logic [p_data_nbits-1:0] resp1_data,
    output logic                    resp1_err,
    output logic                    db_val,
    output logic [p_addr_nbits-1:0] db_src_addr,
    output logic [p_addr_nbits-1:0] db_dest_addr,
    output logic                    db_domain,
    input  logic                    db_result_rdy,
    input  logic [p_data_nbits-1:0] db_result
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t                  state, state_next;
    logic                    ptr;
    logic                    owner;
    logic [p_addr_nbits-1:0] src_q;
    logic [p_addr_nbits-1:0] dest_q;
    logic                    dom_q;
    logic [p_data_nbits-1:0] result_q;
    logic                    grant0, grant1;
    logic                    resp_hs;
    logic                    timeout;
    logic                    active;

    if (p_timeout < 2) begin : g_timeout_check
        $error("p_timeout must be at least 2");
    end

`ifdef PLAB5_MCORE_DEBUG_ARBITER_TIMEOUT_EN
    localparam int CNT_W = (p_timeout > 2) ? $clog2(p_timeout) : 1;
    logic [CNT_W-1:0] cnt;
    logic             err_q;

    assign timeout = (state == BUSY) && (cnt == CNT_W'(p_timeout - 1));

    // Counter restarts every time the arbiter enters BUSY from ISSUE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == ISSUE)
                cnt <= '0;
            else if (state == BUSY)
                cnt <= cnt + 1'b1;
            if (state == BUSY) begin
                if (db_result_rdy)
                    err_q <= 1'b0;
                else if (timeout)
                    err_q <= 1'b1;
            end
        end
    end

    assign resp0_err = resp0_val & err_q;
    assign resp1_err = resp1_val & err_q;
`else
    assign timeout   = 1'b0;
    assign resp0_err = 1'b0;
    assign resp1_err = 1'b0;
`endif

    assign resp_hs = (state == RESP) && (owner ? resp1_rdy : resp0_rdy);

    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                // ptr == 0 gives requester 0 priority when both are valid.
                if (req0_val && (!req1_val || !ptr))
                    grant0 = 1'b1;
                else if (req1_val)
                    grant1 = 1'b1;
                if (grant0 || grant1)
                    state_next = ISSUE;
            end
            ISSUE: state_next = BUSY;
            BUSY: begin
                if (db_result_rdy || timeout)
                    state_next = RESP;
            end
            RESP: begin
                if (resp_hs)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            owner    <= 1'b0;
            src_q    <= '0;
            dest_q   <= '0;
            dom_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state <= state_next;
            if (grant0 || grant1) begin
                owner  <= grant1;
                src_q  <= grant1 ? req1_src_addr  : req0_src_addr;
                dest_q <= grant1 ? req1_dest_addr : req0_dest_addr;
                dom_q  <= grant1 ? req1_domain    : req0_domain;
            end
            if (state == BUSY) begin
                if (db_result_rdy)
                    result_q <= db_result;
                else if (timeout)
                    result_q <= '0;
            end
            if (resp_hs)
                ptr <= ~owner;
        end
    end

    assign active       = (state != IDLE);
    assign req0_rdy     = grant0;
    assign req1_rdy     = grant1;
    assign db_val       = (state == ISSUE);
    assign db_src_addr  = active ? src_q  : '0;
    assign db_dest_addr = active ? dest_q : '0;
    assign db_domain    = active & dom_q;
    assign resp0_val    = (state == RESP) && !owner;
    assign resp1_val    = (state == RESP) && owner;
    assign resp0_data   = resp0_val ? result_q : '0;
    assign resp1_data   = resp1_val ? result_q : '0;

endmodule
